// File: rtl/ase_pkg.sv
// Shared CCI-P write-channel types, encodings and checker error codes.
package ase_pkg;

    localparam int CCIP_DATA_WIDTH  = 512;
    localparam int CCIP_ADDR_WIDTH  = 42;
    localparam int CCIP_MDATA_WIDTH = 16;

    typedef logic [1:0] ccip_vc_t;
    typedef logic [1:0] ccip_len_t;
    typedef logic [3:0] ccip_reqtype_t;

    localparam ccip_len_t ASE_1CL = 2'b00;
    localparam ccip_len_t ASE_2CL = 2'b01;
    localparam ccip_len_t ASE_4CL = 2'b11;

    localparam ccip_reqtype_t ASE_WRLINE_I = 4'h1;
    localparam ccip_reqtype_t ASE_WRLINE_M = 4'h2;
    localparam ccip_reqtype_t ASE_WRFENCE  = 4'h4;

    typedef struct packed {
        ccip_vc_t                    vc;
        logic                        sop;
        ccip_len_t                   len;
        ccip_reqtype_t               reqtype;
        logic [CCIP_ADDR_WIDTH-1:0]  addr;
        logic [CCIP_MDATA_WIDTH-1:0] mdata;
    } TxHdr_t;

    localparam int TX_HDR_WIDTH = $bits(TxHdr_t);

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_NO_SOP       = 3'd1,
        ERR_BAD_LEN      = 3'd2,
        ERR_ALIGN        = 3'd3,
        ERR_SOP_MID      = 3'd4,
        ERR_FENCE_MID    = 3'd5,
        ERR_HDR_MISMATCH = 3'd6,
        ERR_OVERFLOW     = 3'd7
    } ase_err_e;

    function automatic logic len_legal(ccip_len_t len);
        return (len == ASE_1CL) || (len == ASE_2CL) || (len == ASE_4CL);
    endfunction

    // Number of beats following the SOP beat.
    function automatic logic [1:0] len_beats_after_sop(ccip_len_t len);
        unique case (len)
            ASE_2CL: return 2'd1;
            ASE_4CL: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic addr_aligned(ccip_len_t len, logic [1:0] addr_lo);
        if (len == ASE_2CL) return addr_lo[0] == 1'b0;
        if (len == ASE_4CL) return addr_lo == 2'b00;
        return 1'b1;
    endfunction

endpackage

// File: rtl/ase_beat_fifo.sv
// Power-of-two synchronous FIFO with show-ahead read data and occupancy count.
module ase_beat_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, wr_en, rd_en;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    // A pop frees the head slot in the same cycle, so push on full is legal then.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
            else if (!wr_en && rd_en) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/ase_c1tx_beat_checker.sv
// C1Tx beat protocol checker: validates multi-line write packets, drops bad beats,
// and buffers legal beats toward the write channel.
module ase_c1tx_beat_checker
    import ase_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned ALMFULL_THRESH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  TxHdr_t                     in_hdr,
    input  logic [CCIP_DATA_WIDTH-1:0] in_data,
    input  logic                       in_valid,
    output logic                       almfull,
    output TxHdr_t                     out_hdr,
    output logic [CCIP_DATA_WIDTH-1:0] out_data,
    output logic                       out_wr_en,
    input  logic                       chan_full,
    output logic                       err_valid,
    output logic [2:0]                 err_code,
    output logic [15:0]                err_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW = TX_HDR_WIDTH + CCIP_DATA_WIDTH;

    typedef enum logic {StIdle, StMulti} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 beat_idx_q, beat_idx_d;
    logic [1:0]                 beats_left_q, beats_left_d;
    ccip_vc_t                   sop_vc_q, sop_vc_d;
    ccip_len_t                  sop_len_q, sop_len_d;
    ccip_reqtype_t              sop_type_q, sop_type_d;
    ase_err_e                   proto_err, err_d;
    logic                       fwd, overflow, push_d;
    logic                       push_q;
    TxHdr_t                     push_hdr_q;
    logic [CCIP_DATA_WIDTH-1:0] push_data_q;
    logic [FW-1:0]              fifo_rdata;
    logic [CW-1:0]              fifo_count, occ_next;
    logic                       fifo_empty, pop;

    assign pop      = !fifo_empty && !chan_full;
    // Occupancy as it will be once the pending push and any current pop land.
    assign occ_next = fifo_count + CW'(push_q) - CW'(pop);
    assign overflow = in_valid && (occ_next == CW'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        beats_left_d = beats_left_q;
        sop_vc_d     = sop_vc_q;
        sop_len_d    = sop_len_q;
        sop_type_d   = sop_type_q;
        proto_err    = ERR_NONE;
        fwd          = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (!in_hdr.sop) begin
                        proto_err = ERR_NO_SOP;
                    end else if (in_hdr.reqtype == ASE_WRFENCE) begin
                        fwd = 1'b1;
                    end else if (!len_legal(in_hdr.len)) begin
                        proto_err = ERR_BAD_LEN;
                    end else if (!addr_aligned(in_hdr.len, in_hdr.addr[1:0])) begin
                        proto_err = ERR_ALIGN;
                    end else begin
                        fwd = 1'b1;
                        if (in_hdr.len != ASE_1CL) begin
                            state_d      = StMulti;
                            beat_idx_d   = 2'd1;
                            beats_left_d = len_beats_after_sop(in_hdr.len);
                            sop_vc_d     = in_hdr.vc;
                            sop_len_d    = in_hdr.len;
                            sop_type_d   = in_hdr.reqtype;
                        end
                    end
                end
                StMulti: begin
                    if (in_hdr.sop) begin
                        proto_err = ERR_SOP_MID;
                    end else if (in_hdr.reqtype == ASE_WRFENCE) begin
                        proto_err = ERR_FENCE_MID;
                    end else if (in_hdr.vc != sop_vc_q || in_hdr.len != sop_len_q ||
                                 in_hdr.reqtype != sop_type_q ||
                                 in_hdr.addr[1:0] != beat_idx_q) begin
                        proto_err = ERR_HDR_MISMATCH;
                    end else begin
                        fwd = 1'b1;
                    end
                    if (proto_err != ERR_NONE || beats_left_q == 2'd1) begin
                        state_d      = StIdle;
                        beat_idx_d   = 2'd0;
                        beats_left_d = 2'd0;
                    end else begin
                        beat_idx_d   = beat_idx_q + 2'd1;
                        beats_left_d = beats_left_q - 2'd1;
                    end
                end
            endcase
        end
        err_d  = overflow ? ERR_OVERFLOW : proto_err;
        push_d = fwd && !overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_idx_q   <= 2'd0;
            beats_left_q <= 2'd0;
            sop_vc_q     <= '0;
            sop_len_q    <= '0;
            sop_type_q   <= '0;
            push_q       <= 1'b0;
            push_hdr_q   <= '0;
            push_data_q  <= '0;
            out_wr_en    <= 1'b0;
            out_hdr      <= '0;
            out_data     <= '0;
            almfull      <= 1'b0;
            err_valid    <= 1'b0;
            err_code     <= 3'd0;
            err_count    <= 16'd0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            beats_left_q <= beats_left_d;
            sop_vc_q     <= sop_vc_d;
            sop_len_q    <= sop_len_d;
            sop_type_q   <= sop_type_d;
            push_q       <= push_d;
            push_hdr_q   <= in_hdr;
            push_data_q  <= in_data;
            out_wr_en    <= pop;
            if (pop) {out_hdr, out_data} <= fifo_rdata;
            almfull      <= 32'(fifo_count) >= ALMFULL_THRESH;
            err_valid    <= err_d != ERR_NONE;
            err_code     <= err_d;
            if (err_d != ERR_NONE && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

    ase_beat_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .wdata ({push_hdr_q, push_data_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ase_c1tx_beat_checker.sv
// Directed self-checking bench for the C1Tx beat checker.
module tb_ase_c1tx_beat_checker;
    import ase_pkg::*;

    logic                       clk;
    logic                       rst;
    TxHdr_t                     in_hdr;
    logic [CCIP_DATA_WIDTH-1:0] in_data;
    logic                       in_valid;
    logic                       almfull;
    TxHdr_t                     out_hdr;
    logic [CCIP_DATA_WIDTH-1:0] out_data;
    logic                       out_wr_en;
    logic                       chan_full;
    logic                       err_valid;
    logic [2:0]                 err_code;
    logic [15:0]                err_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] got_md[$];
    logic [41:0] got_addr[$];

    ase_c1tx_beat_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_hdr    (in_hdr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .almfull   (almfull),
        .out_hdr   (out_hdr),
        .out_data  (out_data),
        .out_wr_en (out_wr_en),
        .chan_full (chan_full),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_wr_en) begin
            got_md.push_back(out_hdr.mdata);
            got_addr.push_back(out_hdr.addr);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic TxHdr_t mk_hdr(logic sop, ccip_len_t len, ccip_reqtype_t rt,
                                      logic [41:0] addr, logic [15:0] md);
        TxHdr_t h;
        h         = '0;
        h.vc      = 2'b01;
        h.sop     = sop;
        h.len     = len;
        h.reqtype = rt;
        h.addr    = addr;
        h.mdata   = md;
        return h;
    endfunction

    task automatic beat(input TxHdr_t h, input logic [63:0] d);
        in_valid = 1'b1;
        in_hdr   = h;
        in_data  = {8{d}};
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_hdr    = '0;
        in_data   = '0;
        chan_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_wr_en", out_wr_en, 0);
        check("rst_almfull", almfull, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_code", err_code, 0);
        check("rst_err_count", err_count, 0);
        check("rst_out_hdr", out_hdr, 0);
        check("rst_out_data", out_data[63:0], 0);

        // 4CL packet, wr_en expected on cycles 2..5 after the first beat.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_hdr   = mk_hdr(1'(i == 0), ASE_4CL, ASE_WRLINE_I, 42'h8400_0000 + 42'(i),
                                  16'(i));
                in_data  = {8{64'hD0 + 64'(i)}};
            end else begin
                in_valid = 1'b0;
            end
            step();
            check("t1_wr_en", out_wr_en, (i >= 2 && i <= 5));
            check("t1_err_valid", err_valid, 0);
            if (i >= 2 && i <= 5) check("t1_data", out_data[63:0], 64'hD0 + 64'(i - 2));
        end
        check("t1_count", got_md.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("t1_mdata", got_md[k], k);
            check("t1_addr", got_addr[k], 42'h8400_0000 + 42'(k));
        end
        check("t1_err_count", err_count, 0);

        // Illegal len on SOP.
        got_md.delete();
        got_addr.delete();
        beat(mk_hdr(1'b1, 2'b10, ASE_WRLINE_I, 42'h40, 16'h7), 64'hE0);
        check("t2_err_valid", err_valid, 1);
        check("t2_err_code", err_code, 2);
        idle(1);
        check("t2_err_clear", err_valid, 0);
        idle(3);
        check("t2_no_fwd", got_md.size(), 0);
        check("t2_err_count", err_count, 1);

        // Misaligned 2CL dropped, then a 1CL goes through.
        beat(mk_hdr(1'b1, ASE_2CL, ASE_WRLINE_I, 42'h81, 16'h8), 64'hE1);
        check("t3_err_code", err_code, 3);
        beat(mk_hdr(1'b1, ASE_1CL, ASE_WRLINE_M, 42'h100, 16'h55), 64'hE2);
        check("t3_1cl_no_err", err_valid, 0);
        idle(4);
        check("t3_count", got_md.size(), 1);
        check("t3_mdata", got_md[0], 16'h55);
        check("t3_err_count", err_count, 2);

        // Fence mid-packet; FSM must be back in IDLE afterwards.
        got_md.delete();
        got_addr.delete();
        beat(mk_hdr(1'b1, ASE_4CL, ASE_WRLINE_I, 42'h200, 16'h10), 64'hE3);
        check("t4_sop_ok", err_valid, 0);
        beat(mk_hdr(1'b0, ASE_4CL, ASE_WRFENCE, 42'h201, 16'h11), 64'hE4);
        check("t4_err_code", err_code, 5);
        beat(mk_hdr(1'b0, ASE_4CL, ASE_WRLINE_I, 42'h202, 16'h12), 64'hE5);
        check("t4_idle_no_sop", err_code, 1);
        idle(4);
        check("t4_count", got_md.size(), 1);
        check("t4_mdata", got_md[0], 16'h10);
        check("t4_err_count", err_count, 4);

        // Channel stalled: 20 beats, last 4 overflow; almfull lags occupancy by a cycle.
        got_md.delete();
        got_addr.delete();
        chan_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            beat(mk_hdr(1'b1, ASE_1CL, ASE_WRLINE_I, 42'(i), 16'h100 + 16'(i)), 64'(i));
            check("t5_err_valid", err_valid, (i >= 16));
            if (i >= 16) check("t5_err_code", err_code, 7);
            check("t5_almfull", almfull, (i >= 9));
        end
        idle(1);
        check("t5_err_clear", err_valid, 0);
        check("t5_almfull_hold", almfull, 1);
        check("t5_stalled", got_md.size(), 0);
        chan_full = 1'b0;
        idle(20);
        check("t5_count", got_md.size(), 16);
        for (int k = 0; k < 16; k++) check("t5_order", got_md[k], 16'h100 + 16'(k));
        check("t5_almfull_off", almfull, 0);
        check("t5_err_count", err_count, 8);

        // Reset in the middle of a 4CL packet.
        beat(mk_hdr(1'b1, ASE_4CL, ASE_WRLINE_I, 42'h300, 16'h20), 64'hF0);
        beat(mk_hdr(1'b0, ASE_4CL, ASE_WRLINE_I, 42'h301, 16'h21), 64'hF1);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        got_md.delete();
        got_addr.delete();
        check("t6_wr_en", out_wr_en, 0);
        check("t6_out_hdr", out_hdr, 0);
        check("t6_out_data", out_data[63:0], 0);
        check("t6_err_count", err_count, 0);
        check("t6_almfull", almfull, 0);
        beat(mk_hdr(1'b0, ASE_4CL, ASE_WRLINE_I, 42'h302, 16'h22), 64'hF2);
        check("t6_err_code", err_code, 1);
        idle(4);
        check("t6_no_fwd", got_md.size(), 0);
        check("t6_err_count_1", err_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
